// File: rtl/uart_tx_arbiter.sv
// Round-robin scheduler that shares one UART transmitter among N_REQ byte sources.
// Optional frame watchdog is enabled with `define UART_ARB_TIMEOUT_EN.
module uart_tx_arbiter #(
    parameter int N_REQ          = 4,
    parameter int DATA_W         = 8,
    parameter int BAUD_W         = 2,
    parameter int TIMEOUT_CYCLES = 1_000_000
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [N_REQ-1:0]           req,
    input  logic [DATA_W*N_REQ-1:0]    req_data,
    input  logic [BAUD_W*N_REQ-1:0]    req_baud,
    output logic [N_REQ-1:0]           grant_ack,
    output logic                       tx_start,
    output logic [DATA_W-1:0]          tx_data,
    output logic [BAUD_W-1:0]          tx_baud,
    input  logic                       tx_busy,
    input  logic                       tx_done,
    output logic [$clog2(N_REQ)-1:0]   active_id,
    output logic                       arb_busy,
    output logic                       timeout_err
);

    localparam int ID_W = $clog2(N_REQ);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_LOAD      = 3'd1,
        ST_START     = 3'd2,
        ST_WAIT_BUSY = 3'd3,
        ST_WAIT_DONE = 3'd4
    } state_t;

    state_t              state_r;
    logic [ID_W-1:0]     rr_ptr_r;
    logic [ID_W-1:0]     active_id_r;
    logic [DATA_W-1:0]   tx_data_r;
    logic [BAUD_W-1:0]   tx_baud_r;
    logic [N_REQ-1:0]    grant_ack_r;
    logic                tx_start_r;
    logic                arb_busy_r;
    logic                timeout_err_r;

    logic [ID_W-1:0]     winner_s;
    logic [ID_W:0]       rr_idx_s;
    logic                found_s;
    logic [DATA_W-1:0]   sel_data_s;
    logic [BAUD_W-1:0]   sel_baud_s;
    logic [ID_W-1:0]     next_ptr_s;
    logic                timeout_hit_s;

    // Round-robin search: first pending request at or after rr_ptr, wrapping at N_REQ.
    always_comb begin
        winner_s = rr_ptr_r;
        found_s  = 1'b0;
        rr_idx_s = '0;
        for (int i = 0; i < N_REQ; i++) begin
            rr_idx_s = {1'b0, rr_ptr_r} + (ID_W+1)'(i);
            if (rr_idx_s >= (ID_W+1)'(N_REQ)) begin
                rr_idx_s = rr_idx_s - (ID_W+1)'(N_REQ);
            end else begin
                rr_idx_s = rr_idx_s;
            end
            if (!found_s && req[rr_idx_s[ID_W-1:0]]) begin
                winner_s = rr_idx_s[ID_W-1:0];
                found_s  = 1'b1;
            end else begin
                found_s  = found_s;
            end
        end
    end

    // Byte and baud code of the selected requester.
    always_comb begin
        sel_data_s = '0;
        sel_baud_s = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (winner_s == ID_W'(i)) begin
                sel_data_s = req_data[i*DATA_W +: DATA_W];
                sel_baud_s = req_baud[i*BAUD_W +: BAUD_W];
            end else begin
                sel_data_s = sel_data_s;
                sel_baud_s = sel_baud_s;
            end
        end
    end

    assign next_ptr_s = (active_id_r == ID_W'(N_REQ - 1)) ? '0 : (active_id_r + ID_W'(1));

`ifdef UART_ARB_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [CNT_W-1:0] wd_cnt_r;

    // Frame watchdog: cleared on the way into START, counts every waiting cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wd_cnt_r <= '0;
        end else if (state_r == ST_LOAD) begin
            wd_cnt_r <= '0;
        end else if ((state_r == ST_WAIT_BUSY) || (state_r == ST_WAIT_DONE)) begin
            wd_cnt_r <= wd_cnt_r + CNT_W'(1);
        end else begin
            wd_cnt_r <= wd_cnt_r;
        end
    end

    assign timeout_hit_s = ((state_r == ST_WAIT_BUSY) || (state_r == ST_WAIT_DONE)) &&
                           (wd_cnt_r == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    assign timeout_hit_s = 1'b0;
`endif

    // Arbitration FSM; outputs are registered and lag the state decision by one edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r       <= ST_IDLE;
            rr_ptr_r      <= '0;
            active_id_r   <= '0;
            tx_data_r     <= '0;
            tx_baud_r     <= '0;
            grant_ack_r   <= '0;
            tx_start_r    <= 1'b0;
            arb_busy_r    <= 1'b0;
            timeout_err_r <= 1'b0;
        end else begin
            grant_ack_r <= '0;
            tx_start_r  <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if ((|req) && !tx_busy) begin
                        tx_data_r   <= sel_data_s;
                        tx_baud_r   <= sel_baud_s;
                        active_id_r <= winner_s;
                        state_r     <= ST_LOAD;
                        arb_busy_r  <= 1'b1;
                    end else begin
                        arb_busy_r  <= 1'b0;
                    end
                end
                ST_LOAD: begin
                    grant_ack_r <= {{(N_REQ-1){1'b0}}, 1'b1} << active_id_r;
                    state_r     <= ST_START;
                end
                ST_START: begin
                    tx_start_r <= 1'b1;
                    state_r    <= ST_WAIT_BUSY;
                end
                ST_WAIT_BUSY, ST_WAIT_DONE: begin
                    // A fast transmitter may finish before busy is ever seen.
                    if (tx_done) begin
                        state_r    <= ST_IDLE;
                        rr_ptr_r   <= next_ptr_s;
                        arb_busy_r <= 1'b0;
                    end else if (timeout_hit_s) begin
                        state_r       <= ST_IDLE;
                        rr_ptr_r      <= next_ptr_s;
                        arb_busy_r    <= 1'b0;
                        timeout_err_r <= 1'b1;
                    end else if ((state_r == ST_WAIT_BUSY) && tx_busy) begin
                        state_r <= ST_WAIT_DONE;
                    end else begin
                        state_r <= state_r;
                    end
                end
                default: begin
                    state_r    <= ST_IDLE;
                    arb_busy_r <= 1'b0;
                end
            endcase
        end
    end

    assign grant_ack   = grant_ack_r;
    assign tx_start    = tx_start_r;
    assign tx_data     = tx_data_r;
    assign tx_baud     = tx_baud_r;
    assign active_id   = active_id_r;
    assign arb_busy    = arb_busy_r;
    assign timeout_err = timeout_err_r;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed self-checking bench for uart_tx_arbiter (N_REQ=4, TIMEOUT_CYCLES=100).
module tb_uart_tx_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  req;
    logic [31:0] req_data;
    logic [7:0]  req_baud;
    logic [3:0]  grant_ack;
    logic        tx_start;
    logic [7:0]  tx_data;
    logic [1:0]  tx_baud;
    logic        tx_busy;
    logic        tx_done;
    logic [1:0]  active_id;
    logic        arb_busy;
    logic        timeout_err;

    logic        man_busy, man_done, model_en;
    logic        m_busy, m_done;
    int          m_cnt;
    int          n_checks = 0;
    int          n_fail   = 0;
    int          n;
    logic [3:0]  grant_log[$];
    logic [7:0]  data_log[$];
    logic [18:0] outs;
    logic [3:0]  exp_ack;

    always #5 clk = ~clk;

    uart_tx_arbiter #(
        .N_REQ(4), .DATA_W(8), .BAUD_W(2), .TIMEOUT_CYCLES(100)
    ) dut (
        .clk(clk), .reset(reset), .req(req), .req_data(req_data), .req_baud(req_baud),
        .grant_ack(grant_ack), .tx_start(tx_start), .tx_data(tx_data), .tx_baud(tx_baud),
        .tx_busy(tx_busy), .tx_done(tx_done), .active_id(active_id),
        .arb_busy(arb_busy), .timeout_err(timeout_err)
    );

    assign tx_busy = model_en ? m_busy : man_busy;
    assign tx_done = model_en ? m_done : man_done;
    assign outs    = {grant_ack, tx_start, tx_data, tx_baud, active_id, arb_busy, timeout_err};

    // Simple UART TX model: busy for 20 cycles after a start pulse, then a done pulse.
    always @(posedge clk) begin
        if (!model_en) begin
            m_busy <= 1'b0;
            m_done <= 1'b0;
            m_cnt  <= 0;
        end else begin
            m_done <= 1'b0;
            if (tx_start && !m_busy) begin
                m_busy <= 1'b1;
                m_cnt  <= 20;
            end else if (m_busy) begin
                if (m_cnt == 1) begin
                    m_busy <= 1'b0;
                    m_done <= 1'b1;
                end
                m_cnt <= m_cnt - 1;
            end
        end
    end

    // Record every grant pulse together with the byte latched for it.
    always @(posedge clk) begin
        if (reset === 1'b1 && |grant_ack) begin
            grant_log.push_back(grant_ack);
            data_log.push_back(tx_data);
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        reset    = 1'b0;
        req      = 4'b0000;
        req_data = 32'h0;
        req_baud = 8'h0;
        man_busy = 1'b0;
        man_done = 1'b0;
        model_en = 1'b0;

        // 1: reset held with random requests
        for (int i = 0; i < 4; i++) begin
            req      = 4'($urandom);
            req_data = $urandom;
            req_baud = 8'($urandom);
            tick();
            chk("t1_reset_outs", 32'(outs), 32'h0);
        end
        req = 4'b0000;
        reset = 1'b1;
        tick();
        tick();
        chk("t1_idle_after_release", 32'(outs), 32'h0);

        // 2: single request from id 2
        req_data = {8'h44, 8'hA5, 8'h22, 8'h11};
        req_baud = 8'b00_11_01_10;
        req      = 4'b0100;
        tick();
        chk("t2_latch", 32'({arb_busy, active_id, tx_data, tx_baud, grant_ack}),
            32'({1'b1, 2'd2, 8'hA5, 2'b11, 4'b0000}));
        tick();
        chk("t2_grant", 32'({grant_ack, tx_start}), 32'({4'b0100, 1'b0}));
        req      = 4'b0000;
        req_data = {8'h44, 8'h00, 8'h22, 8'h11};
        req_baud = 8'b00_00_01_10;
        tick();
        chk("t2_start", 32'({grant_ack, tx_start}), 32'({4'b0000, 1'b1}));
        tick();
        chk("t2_start_end", 32'(tx_start), 32'h0);
        man_busy = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("t2_hold", 32'({arb_busy, tx_data, tx_baud}), 32'({1'b1, 8'hA5, 2'b11}));
        end
        man_busy = 1'b0;
        man_done = 1'b1;
        tick();
        man_done = 1'b0;
        chk("t2_done", 32'({arb_busy, tx_data, tx_baud}), 32'({1'b0, 8'hA5, 2'b11}));

        // 5: busy transmitter blocks a grant; reset during WAIT_DONE
        req_data = {8'h13, 8'h12, 8'h11, 8'h10};
        req_baud = 8'b11_10_01_00;
        man_busy = 1'b1;
        req      = 4'b0001;
        repeat (5) tick();
        chk("t5_blocked", 32'({arb_busy, grant_ack}), 32'h0);
        man_busy = 1'b0;
        tick();
        chk("t5_latch", 32'({arb_busy, active_id, tx_data}), 32'({1'b1, 2'd0, 8'h10}));
        tick();
        chk("t5_grant", 32'(grant_ack), 32'(4'b0001));
        req = 4'b0000;
        tick();
        chk("t5_start", 32'(tx_start), 32'h1);
        man_busy = 1'b1;
        tick();
        tick();
        chk("t5_wait_done", 32'(arb_busy), 32'h1);
        #3;
        reset = 1'b0;
        #1;
        chk("t5_async_reset", 32'(outs), 32'h0);
        man_busy = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        chk("t5_after_reset", 32'(outs), 32'h0);

        // 3: all four requesting, TX model busy 20 cycles per frame
        grant_log.delete();
        data_log.delete();
        model_en = 1'b1;
        req      = 4'b1111;
        n = 0;
        while (grant_log.size() < 5 && n < 400) begin
            tick();
            n++;
        end
        req = 4'b0000;
        chk("t3_grant_count", 32'(grant_log.size()), 32'd5);
        for (int i = 0; i < 5; i++) begin
            if (i < grant_log.size()) begin
                exp_ack = 4'b0001 << (i % 4);
                chk("t3_order", 32'(grant_log[i]), 32'(exp_ack));
                chk("t3_data", 32'(data_log[i]), 32'(8'h10 + 8'(i % 4)));
            end
        end
        n = 0;
        while (arb_busy !== 1'b0 && n < 100) begin
            tick();
            n++;
        end
        chk("t3_idle", 32'(arb_busy), 32'h0);
        chk("t3_no_extra_grant", 32'(grant_log.size()), 32'd5);

        // 4: serve id 1, then ids 0 and 2 together -> 2 before 0
        grant_log.delete();
        data_log.delete();
        req = 4'b0010;
        n = 0;
        while (grant_log.size() < 1 && n < 100) begin
            tick();
            n++;
        end
        req = 4'b0000;
        n = 0;
        while (arb_busy !== 1'b0 && n < 100) begin
            tick();
            n++;
        end
        req = 4'b0101;
        n = 0;
        while (grant_log.size() < 3 && n < 200) begin
            tick();
            n++;
        end
        req = 4'b0000;
        n = 0;
        while (arb_busy !== 1'b0 && n < 100) begin
            tick();
            n++;
        end
        chk("t4_grant_count", 32'(grant_log.size()), 32'd3);
        if (grant_log.size() >= 3) begin
            chk("t4_first", 32'(grant_log[0]), 32'(4'b0010));
            chk("t4_second", 32'(grant_log[1]), 32'(4'b0100));
            chk("t4_third", 32'(grant_log[2]), 32'(4'b0001));
        end
        model_en = 1'b0;
        tick();

        // 6: transmitter never answers
        req = 4'b0010;
        tick();
        chk("t6_latch", 32'({arb_busy, active_id}), 32'({1'b1, 2'd1}));
        tick();
        chk("t6_grant", 32'(grant_ack), 32'(4'b0010));
        req = 4'b0100;
`ifdef UART_ARB_TIMEOUT_EN
        n = 0;
        while (timeout_err !== 1'b1 && n < 300) begin
            tick();
            n++;
        end
        chk("t6_timeout_err", 32'({timeout_err, arb_busy}), 32'({1'b1, 1'b0}));
        tick();
        chk("t6_next_latch", 32'({arb_busy, active_id}), 32'({1'b1, 2'd2}));
        tick();
        chk("t6_next_grant", 32'(grant_ack), 32'(4'b0100));
        req = 4'b0000;
        tick();
        man_done = 1'b1;
        tick();
        man_done = 1'b0;
        chk("t6_sticky", 32'({timeout_err, arb_busy}), 32'({1'b1, 1'b0}));
`else
        repeat (150) tick();
        chk("t6_no_timeout", 32'({timeout_err, arb_busy}), 32'({1'b0, 1'b1}));
        man_done = 1'b1;
        tick();
        man_done = 1'b0;
        chk("t6_fast_done", 32'(arb_busy), 32'h0);
        tick();
        chk("t6_next_latch", 32'({arb_busy, active_id}), 32'({1'b1, 2'd2}));
        tick();
        chk("t6_next_grant", 32'(grant_ack), 32'(4'b0100));
        req = 4'b0000;
        tick();
        man_done = 1'b1;
        tick();
        man_done = 1'b0;
        chk("t6_end", 32'({timeout_err, arb_busy}), 32'h0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
